gray_step_tracker: RTL and testbench

//  Downstream consumer of the combinational binary-to-Gray encoder.
//  - Accepts a stream of W-bit Gray codes on a valid/ready handshake.
//  - Registers the Gray-to-binary result on a one-entry output stage.
//  - Checks that each accepted code differs from the previous one in at most one bit.
//  - Counts and flags any illegal multi-bit step.

---
 rtl/gray_pkg.sv | 33 +++
 rtl/gray_step_tracker_if.sv | 35 +++
 rtl/gray_to_bin.sv | 19 +
 rtl/gray_step_tracker.sv | 121 ++++++++++++
 tb/tb_gray_step_tracker.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray step tracker.
// Holds the FSM state type, default widths and bit-level helper functions.
package gray_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_RESYNC
  } state_t;

  // Prefix XOR from the MSB down; zero upper bits leave low bits intact.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_step_tracker_if.sv
// Valid/ready stream bundle for the Gray step tracker.
// Input side carries Gray codes; output side carries decoded words.
interface gray_step_tracker_if #(
  parameter int W = gray_pkg::W_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         step_err;

  modport master (
    output in_valid,
    input  in_ready,
    output in_gray,
    input  out_valid,
    output out_ready,
    input  out_bin,
    input  step_err
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_gray,
    output out_valid,
    input  out_ready,
    output out_bin,
    output step_err
  );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational W-bit Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Ripple the prefix XOR from the MSB downwards.
  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_step_tracker.sv
// Gray stream checker: decodes, registers and flags multi-bit steps.
// Optional macro GRAY_TRACK_DIR_EN adds the dir_up output.
module gray_step_tracker
  import gray_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  gray_step_tracker_if.slave bus,
  input  logic          clr_err,
  output logic          fault,
`ifdef GRAY_TRACK_DIR_EN
  output logic          dir_up,
`endif
  output logic [CW-1:0] err_count
);

  state_t        state;
  state_t        state_d;
  logic [W-1:0]  prev_gray;
  logic [W-1:0]  dec_bin;
  logic          accept;
  logic          xfer;
  logic          multi;
  logic          illegal;
  logic          ov_q;
  logic [W-1:0]  bin_q;
  logic          err_q;
  logic [CW-1:0] cnt_base;
  logic          cnt_sat;

  gray_to_bin #(.W(W)) u_dec (
    .gray (bus.in_gray),
    .bin  (dec_bin)
  );

  assign bus.in_ready  = !ov_q || bus.out_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_bin   = bin_q;
  assign bus.step_err  = err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = ov_q && bus.out_ready;
  assign multi  = popcount(32'(prev_gray ^ bus.in_gray)) > 1;

  assign cnt_base = clr_err ? '0 : err_count;
  assign cnt_sat  = &cnt_base;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state; only a tracked accept can be illegal.
  always_comb begin
    state_d = state;
    illegal = 1'b0;
    if (accept) begin
      unique case (state)
        S_IDLE:   state_d = S_TRACK;
        S_TRACK: begin
          illegal = multi;
          state_d = multi ? S_RESYNC : S_TRACK;
        end
        S_RESYNC: state_d = S_TRACK;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Last accepted code, the reference for the next step check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prev_gray <= '0;
    else if (accept) prev_gray <= bus.in_gray;
  end

  // One-entry output stage; held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q  <= 1'b0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      ov_q  <= 1'b1;
      bin_q <= dec_bin;
      err_q <= illegal;
    end else if (xfer) begin
      ov_q  <= 1'b0;
    end
  end

  // Sticky fault and saturating counter; clear lands before increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault     <= 1'b0;
      err_count <= '0;
    end else begin
      fault     <= illegal || (fault && !clr_err);
      err_count <= (illegal && !cnt_sat) ? cnt_base + CW'(1) : cnt_base;
    end
  end

`ifdef GRAY_TRACK_DIR_EN
  logic [W-1:0] prev_bin;
  logic         up;

  assign prev_bin = W'(gray2bin(32'(prev_gray)));
  assign up = (state == S_TRACK) && !multi &&
              (dec_bin == prev_bin + W'(1));

  // Direction flag travels with the decoded word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dir_up <= 1'b0;
    else if (accept) dir_up <= up;
  end
`endif

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed self-checking bench for gray_step_tracker (W=4, CW=8).
// Covers dir_up checks when GRAY_TRACK_DIR_EN is defined.
module tb_gray_step_tracker;

  logic       clk;
  logic       rst;
  logic       clr_err;
  logic       fault;
  logic [7:0] err_count;
`ifdef GRAY_TRACK_DIR_EN
  logic       dir_up;
`endif

  int n_chk;
  int n_fail;

  logic [3:0] tbl [17] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000,
    4'b0000
  };

  gray_step_tracker_if #(.W(4)) bus ();

  gray_step_tracker #(.W(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_err   (clr_err),
    .fault     (fault),
`ifdef GRAY_TRACK_DIR_EN
    .dir_up    (dir_up),
`endif
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.in_valid  = 1'b0;
    bus.in_gray   = 4'b0000;
    bus.out_ready = 1'b1;
    clr_err       = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic [3:0] g);
    bus.in_valid  = 1'b1;
    bus.in_gray   = g;
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.in_gray   = 4'b0000;
    bus.out_ready = 1'b0;
    clr_err       = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL rst_ov got %b want 0", bus.out_valid); n_fail++;
    end
    n_chk++;
    if (bus.out_bin !== 4'b0000) begin
      $display("FAIL rst_bin got %b want 0000", bus.out_bin); n_fail++;
    end
    n_chk++;
    if (bus.step_err !== 1'b0) begin
      $display("FAIL rst_err got %b want 0", bus.step_err); n_fail++;
    end
    n_chk++;
    if (fault !== 1'b0 || err_count !== 8'd0) begin
      $display("FAIL rst_cnt got %b/%0d want 0/0", fault, err_count);
      n_fail++;
    end
    rst = 1'b0;
    #1;
    send(4'b1010);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'b1100) begin
      $display("FAIL first_word got %b/%b want 1/1100",
               bus.out_valid, bus.out_bin);
      n_fail++;
    end
    n_chk++;
    if (bus.step_err !== 1'b0) begin
      $display("FAIL first_err got %b want 0", bus.step_err); n_fail++;
    end
  endtask

  task automatic test_count;
    do_reset;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus.in_gray = tbl[k];
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
        $display("FAIL cnt_rdy k=%0d got %b want 1", k, bus.in_ready);
        n_fail++;
      end
      tick;
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'(k % 16) ||
          bus.step_err !== 1'b0) begin
        $display("FAIL cnt_bin k=%0d got %b/%0d/%b want 1/%0d/0",
                 k, bus.out_valid, bus.out_bin, bus.step_err, k % 16);
        n_fail++;
      end
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (fault !== 1'b0 || err_count !== 8'd0) begin
      $display("FAIL cnt_err got %b/%0d want 0/0", fault, err_count);
      n_fail++;
    end
  endtask

  task automatic test_illegal;
    do_reset;
    send(4'b0000);
    send(4'b0011);
    n_chk++;
    if (bus.step_err !== 1'b1 || bus.out_bin !== 4'b0010) begin
      $display("FAIL ill_step got %b/%b want 1/0010",
               bus.step_err, bus.out_bin);
      n_fail++;
    end
    n_chk++;
    if (fault !== 1'b1 || err_count !== 8'd1) begin
      $display("FAIL ill_cnt got %b/%0d want 1/1", fault, err_count);
      n_fail++;
    end
    send(4'b0010);
    n_chk++;
    if (bus.step_err !== 1'b0) begin
      $display("FAIL resync got %b want 0", bus.step_err); n_fail++;
    end
    send(4'b0110);
    n_chk++;
    if (bus.step_err !== 1'b0 || err_count !== 8'd1) begin
      $display("FAIL legal got %b/%0d want 0/1", bus.step_err, err_count);
      n_fail++;
    end
    send(4'b0000);
    n_chk++;
    if (bus.step_err !== 1'b1 || err_count !== 8'd2) begin
      $display("FAIL ill2 got %b/%0d want 1/2", bus.step_err, err_count);
      n_fail++;
    end
    send(4'b0111);
    n_chk++;
    if (bus.step_err !== 1'b0 || err_count !== 8'd2) begin
      $display("FAIL resync2 got %b/%0d want 0/2", bus.step_err, err_count);
      n_fail++;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    send(4'b0001);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_gray   = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_bin !== 4'd1) begin
        $display("FAIL stall c=%0d got %b/%b/%0d want 0/1/1",
                 c, bus.in_ready, bus.out_valid, bus.out_bin);
        n_fail++;
      end
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL release_rdy got %b want 1", bus.in_ready); n_fail++;
    end
    tick;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'd2) begin
      $display("FAIL release_b got %b/%0d want 1/2",
               bus.out_valid, bus.out_bin);
      n_fail++;
    end
    bus.in_gray = 4'b0010;
    tick;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'd3) begin
      $display("FAIL release_c got %b/%0d want 1/3",
               bus.out_valid, bus.out_bin);
      n_fail++;
    end
    bus.in_valid = 1'b0;
    tick;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL drain got %b want 0", bus.out_valid); n_fail++;
    end
  endtask

  task automatic test_clr_sat;
    do_reset;
    send(4'b0000);
    send(4'b0011);
    send(4'b0000);
    send(4'b0011);
    send(4'b0000);
    n_chk++;
    if (err_count !== 8'd2) begin
      $display("FAIL pre_clr got %0d want 2", err_count); n_fail++;
    end
    clr_err = 1'b1;
    send(4'b0011);
    clr_err = 1'b0;
    n_chk++;
    if (err_count !== 8'd1 || fault !== 1'b1) begin
      $display("FAIL clr_ill got %0d/%b want 1/1", err_count, fault);
      n_fail++;
    end
    bus.out_ready = 1'b0;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    n_chk++;
    if (err_count !== 8'd0 || fault !== 1'b0) begin
      $display("FAIL clr_only got %0d/%b want 0/0", err_count, fault);
      n_fail++;
    end
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'b0010 ||
        bus.step_err !== 1'b1) begin
      $display("FAIL clr_hold got %b/%b/%b want 1/0010/1",
               bus.out_valid, bus.out_bin, bus.step_err);
      n_fail++;
    end
    for (int i = 0; i < 300; i++) begin
      send(4'b0000);
      send(4'b0011);
      if (i == 253) begin
        n_chk++;
        if (err_count !== 8'hFE) begin
          $display("FAIL sat_pre got %0d want 254", err_count); n_fail++;
        end
      end
    end
    n_chk++;
    if (err_count !== 8'hFF) begin
      $display("FAIL sat got %0d want 255", err_count); n_fail++;
    end
    n_chk++;
    if (fault !== 1'b1 || bus.step_err !== 1'b1) begin
      $display("FAIL sat_flag got %b/%b want 1/1", fault, bus.step_err);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_gray   = 4'b0001;
    tick;
    bus.in_valid  = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL mid_pre got %b want 1", bus.out_valid); n_fail++;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL mid_rst got %b want 0", bus.out_valid); n_fail++;
    end
    rst = 1'b0;
    #1;
    send(4'b0111);
    n_chk++;
    if (bus.step_err !== 1'b0 || err_count !== 8'd0 ||
        bus.out_bin !== 4'b0101) begin
      $display("FAIL mid_next got %b/%0d/%b want 0/0/0101",
               bus.step_err, err_count, bus.out_bin);
      n_fail++;
    end
  endtask

`ifdef GRAY_TRACK_DIR_EN
  task automatic test_dir;
    do_reset;
    send(4'b0001);
    n_chk++;
    if (dir_up !== 1'b0) begin
      $display("FAIL dir_first got %b want 0", dir_up); n_fail++;
    end
    send(4'b0011);
    n_chk++;
    if (dir_up !== 1'b1) begin
      $display("FAIL dir_up got %b want 1", dir_up); n_fail++;
    end
    send(4'b0011);
    n_chk++;
    if (dir_up !== 1'b0) begin
      $display("FAIL dir_hold got %b want 0", dir_up); n_fail++;
    end
    send(4'b0001);
    n_chk++;
    if (dir_up !== 1'b0) begin
      $display("FAIL dir_down got %b want 0", dir_up); n_fail++;
    end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    test_reset;
    test_count;
    test_illegal;
    test_backpressure;
    test_clr_sat;
    test_reset_mid;
`ifdef GRAY_TRACK_DIR_EN
    test_dir;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
